// File: rtl/anton_neopixel_pkg.sv
// anton_neopixel_pkg: register map, ctrl bit positions and loader FSM encodings
package anton_neopixel_pkg;
  localparam logic [13:0] REG_BASE_DEF = 14'h2000;
  localparam logic [13:0] OFF_MAX_LO = 14'd0;
  localparam logic [13:0] OFF_MAX_HI = 14'd1;
  localparam logic [13:0] OFF_CTRL = 14'd2;
  localparam int CTRL_INIT = 0;
  localparam int CTRL_LIMIT = 1;
  localparam int CTRL_RUN = 2;
  localparam int CTRL_LOOP = 3;
  localparam int CTRL_32BIT = 4;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WR_MAX_LO, S_WR_MAX_HI, S_WR_CTRL, S_DONE, S_WAIT_SYNC
  } state_e;
  function automatic logic [7:0] ctrl_byte(input logic b32, input logic loop);
    logic [7:0] c;
    c = '0;
    c[CTRL_32BIT] = b32;
    c[CTRL_LOOP] = loop;
    c[CTRL_RUN] = 1'b1;
    c[CTRL_LIMIT] = 1'b1;
    c[CTRL_INIT] = 1'b0;
    return c;
  endfunction
endpackage

// File: rtl/anton_sync2.sv
// anton_sync2: two-flop synchronizer with asynchronous active-low reset
module anton_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] s_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= '0;
    else s_q <= {s_q[0], d};
  assign q = s_q[1];
endmodule

// File: rtl/anton_neopixel_frame_loader.sv
// anton_neopixel_frame_loader: streams frame bytes into the neopixel buffer, then programs max/ctrl.
// Define ANTON_NEOPIXEL_LOADER_TEAR_GUARD_EN to hold the first write until the controller reset window opens.
module anton_neopixel_frame_loader
  import anton_neopixel_pkg::*;
#(
  parameter int          PIXELS_MAX = 66,
  parameter logic [13:0] REG_BASE   = REG_BASE_DEF
) (
  input  logic        busClk,
  input  logic        busResetN,
  input  logic [7:0]  byteData,
  input  logic        byteValid,
  input  logic        byteFirst,
  input  logic        byteLast,
  output logic        byteReady,
  input  logic        cfg32bit,
  input  logic        cfgLoop,
  input  logic        neoState,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busy,
  output logic        frameDone,
  output logic        overflow
);
  localparam logic [15:0] PMAX = 16'(PIXELS_MAX);
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic wr_q, wr_d, done_q, done_d, ovf_q, ovf_d, c32_q, c32_d, loop_q, loop_d, rdy_q;
  logic hs;
  logic [15:0] max_v, cnt_inc;
`ifdef ANTON_NEOPIXEL_LOADER_TEAR_GUARD_EN
  logic neo_s, neo_prev_q, neo_rise;
  logic [7:0] skid_q, skid_d;
  logic skid_last_q, skid_last_d;
  anton_sync2 u_sync (.clk(busClk), .rst_n(busResetN), .d(neoState), .q(neo_s));
  assign neo_rise = neo_s & ~neo_prev_q;
`else
  logic unused_neo;
  assign unused_neo = neoState;
`endif
  assign byteReady = rdy_q & (state_q == S_IDLE || state_q == S_LOAD);
  assign hs = byteValid & byteReady;
  assign max_v = cnt_q > PMAX ? PMAX : cnt_q;
  assign cnt_inc = cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    wr_d = 1'b0;
    done_d = 1'b0;
    ovf_d = ovf_q;
    c32_d = c32_q;
    loop_d = loop_q;
`ifdef ANTON_NEOPIXEL_LOADER_TEAR_GUARD_EN
    skid_d = skid_q;
    skid_last_d = skid_last_q;
`endif
    case (state_q)
      S_IDLE: if (hs && byteFirst) begin
        c32_d = cfg32bit;
        loop_d = cfgLoop;
        ovf_d = 1'b0;
`ifdef ANTON_NEOPIXEL_LOADER_TEAR_GUARD_EN
        skid_d = byteData;
        skid_last_d = byteLast;
        state_d = S_WAIT_SYNC;
`else
        wr_d = 1'b1;
        addr_d = '0;
        data_d = byteData;
        cnt_d = 16'd1;
        state_d = byteLast ? S_WR_MAX_LO : S_LOAD;
`endif
      end
`ifdef ANTON_NEOPIXEL_LOADER_TEAR_GUARD_EN
      S_WAIT_SYNC: if (neo_rise) begin
        wr_d = 1'b1;
        addr_d = '0;
        data_d = skid_q;
        cnt_d = 16'd1;
        state_d = skid_last_q ? S_WR_MAX_LO : S_LOAD;
      end
`endif
      S_LOAD: if (hs) begin
        if (byteFirst) begin
          wr_d = 1'b1;
          addr_d = '0;
          data_d = byteData;
          cnt_d = 16'd1;
          ovf_d = 1'b0;
          c32_d = cfg32bit;
          loop_d = cfgLoop;
        end else if (cnt_q >= PMAX) begin
          ovf_d = 1'b1;
          cnt_d = cnt_inc;
        end else begin
          wr_d = 1'b1;
          addr_d = cnt_q[13:0];
          data_d = byteData;
          cnt_d = cnt_inc;
        end
        if (byteLast) state_d = S_WR_MAX_LO;
      end
      S_WR_MAX_LO: begin
        wr_d = 1'b1;
        addr_d = REG_BASE + OFF_MAX_LO;
        data_d = max_v[7:0];
        state_d = S_WR_MAX_HI;
      end
      S_WR_MAX_HI: begin
        wr_d = 1'b1;
        addr_d = REG_BASE + OFF_MAX_HI;
        data_d = max_v[15:8];
        state_d = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        wr_d = 1'b1;
        addr_d = REG_BASE + OFF_CTRL;
        data_d = ctrl_byte(c32_q, loop_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // rdy_q keeps byteReady low while reset is held and for the first cycle after
  always_ff @(posedge busClk or negedge busResetN)
    if (!busResetN) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      c32_q <= 1'b0;
      loop_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q <= wr_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      c32_q <= c32_d;
      loop_q <= loop_d;
      rdy_q <= 1'b1;
    end
`ifdef ANTON_NEOPIXEL_LOADER_TEAR_GUARD_EN
  always_ff @(posedge busClk or negedge busResetN)
    if (!busResetN) begin
      neo_prev_q <= 1'b0;
      skid_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      neo_prev_q <= neo_s;
      skid_q <= skid_d;
      skid_last_q <= skid_last_d;
    end
`endif
  assign busAddr = addr_q;
  assign busDataIn = data_q;
  assign busWrite = wr_q;
  assign busy = state_q != S_IDLE;
  assign frameDone = done_q;
  assign overflow = ovf_q;
endmodule
